// File: rtl/i3c_srst_pkg.sv
// Shared encodings for the oversampled I3C target-reset detector:
// RSTACT action codes and detector FSM states.
package i3c_srst_pkg;

   typedef logic [2:0] ract_t;
   typedef logic [2:0] srst_state_t;

   localparam ract_t RACT_DEF  = 3'd0;
   localparam ract_t RACT_FULL = 3'd1;
   localparam ract_t RACT_NONE = 3'd2;
   localparam ract_t RACT_CUST = 3'd3;

   localparam srst_state_t IDLE    = 3'd0;
   localparam srst_state_t COUNT   = 3'd1;
   localparam srst_state_t ARMED   = 3'd2;
   localparam srst_state_t WAIT_SR = 3'd3;
   localparam srst_state_t WAIT_P  = 3'd4;
   localparam srst_state_t ACTIVE  = 3'd5;

endpackage

// File: rtl/i3c_reset_detector_sync_if.sv
// Bus-side bundle of the reset detector: raw pins, RSTACT controls and reset outputs.
// master drives pins/controls, slave is the detector.
interface i3c_reset_detector_sync_if #(
   parameter int unsigned ESC_W = 3
);

   logic             pin_SCL_in;
   logic             pin_SDA_in;
   logic             iDeepestSleep;
   logic [3:0]       iRstAction;
   logic             oWake;
   logic             oRstBlock;
   logic             oRstAll;
   logic             oRstCustom;
   logic             oRstRstAction;
   logic [ESC_W-1:0] oEscCnt;

   modport master (
      output pin_SCL_in, pin_SDA_in, iDeepestSleep, iRstAction,
      input  oWake, oRstBlock, oRstAll, oRstCustom, oRstRstAction, oEscCnt
   );

   modport slave (
      input  pin_SCL_in, pin_SDA_in, iDeepestSleep, iRstAction,
      output oWake, oRstBlock, oRstAll, oRstCustom, oRstRstAction, oEscCnt
   );

endinterface

// File: rtl/i3c_reset_detector_sync_pin_filter.sv
// Two-flop synchroniser, FILT_CYC-sample agreement filter and edge strobes for one pin.
// Lines reset to the idle-high bus level.
module i3c_pin_filter #(
   parameter int unsigned FILT_CYC = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic filt_o,
   output logic rise_o,
   output logic fall_o
);

   // [0],[1] are the synchroniser; [FILT_CYC:1] is the agreement window.
   logic [FILT_CYC:0] smp_q, smp_d;
   logic              filt_q, filt_d;
   logic              prev_q, prev_d;

   always_comb begin
      smp_d  = {smp_q[FILT_CYC-1:0], pin_i};
      filt_d = filt_q;
      if (&smp_q[FILT_CYC:1]) begin
         filt_d = 1'b1;
      end else if (~|smp_q[FILT_CYC:1]) begin
         filt_d = 1'b0;
      end
      prev_d = filt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         smp_q  <= '1;
         filt_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         smp_q  <= smp_d;
         filt_q <= filt_d;
         prev_q <= prev_d;
      end
   end

   assign filt_o = filt_q;
   assign rise_o = filt_q & ~prev_q;
   assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/i3c_reset_detector_sync.sv
// Oversampled I3C target-reset (SRST) detector: N SDA falls with SCL low, then Sr, then P.
// Drives peripheral/system/custom reset, wake and RSTACT-restore outputs.
module i3c_reset_detector_sync
   import i3c_srst_pkg::*;
#(
   parameter int unsigned SRST_EDGES = 7,
   parameter int unsigned FILT_CYC   = 2,
   parameter int unsigned ESC_LIMIT  = 1,
   parameter int unsigned ESC_W      = 3
) (
   input logic                          clk,
   input logic                          RST,
   input logic                          i3c_slave_active,
   i3c_reset_detector_sync_if.slave     bus
);

   localparam logic [3:0]       EdgeMax = 4'(SRST_EDGES);
   localparam logic [ESC_W-1:0] EscLim  = ESC_W'(ESC_LIMIT);
   localparam logic [ESC_W-1:0] EscMax  = '1;

   logic srst;
   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;
   logic sda_rise_v, sda_fall_v;
   ract_t act;
   logic clr;
   logic match;
   logic [3:0] cnt_inc;

   srst_state_t      state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [ESC_W-1:0] esc_q, esc_d;
   logic             all_q, all_d;
   logic             wake_q, wake_d;
   logic             blk_q, blk_d;
   logic             cust_q, cust_d;
   logic             ract_q, ract_d;
   logic             active_d;

   assign srst = RST | ~i3c_slave_active;

   i3c_pin_filter #(.FILT_CYC(FILT_CYC)) u_scl (
      .clk_i  (clk),
      .rst_i  (srst),
      .pin_i  (bus.pin_SCL_in),
      .filt_o (scl_f),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i3c_pin_filter #(.FILT_CYC(FILT_CYC)) u_sda (
      .clk_i  (clk),
      .rst_i  (srst),
      .pin_i  (bus.pin_SDA_in),
      .filt_o (sda_f),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   // An SCL edge in the same cycle masks any SDA edge.
   assign sda_fall_v = sda_fall & ~scl_rise & ~scl_fall;
   assign sda_rise_v = sda_rise & ~scl_rise & ~scl_fall;

   assign act     = bus.iDeepestSleep ? RACT_NONE : bus.iRstAction[2:0];
   assign clr     = ~bus.iDeepestSleep & bus.iRstAction[3];
   assign cnt_inc = (cnt_q < EdgeMax) ? cnt_q + 4'd1 : cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      match   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sda_fall_v && !scl_f) begin
               cnt_d   = 4'd1;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (scl_rise) begin
               state_d = IDLE;
            end else if (sda_fall_v && !scl_f) begin
               cnt_d = cnt_inc;
               if (cnt_inc == EdgeMax) state_d = ARMED;
            end
         end
         ARMED: begin
            if (scl_rise) state_d = sda_f ? WAIT_SR : IDLE;
         end
         WAIT_SR: begin
            if (scl_fall) begin
               state_d = IDLE;
            end else if (sda_fall_v && scl_f) begin
               state_d = WAIT_P;
            end
         end
         WAIT_P: begin
            if (scl_fall) begin
               state_d = IDLE;
            end else if (sda_rise_v && scl_f) begin
               state_d = ACTIVE;
               match   = 1'b1;
            end
         end
         ACTIVE: begin
            if (scl_fall || clr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) cnt_d = '0;
   end

   // Outputs are registered from the next state so they land with the FSM transition.
   always_comb begin
      all_d = all_q | (match & ((act == RACT_FULL) | (esc_q >= EscLim)));
      esc_d = esc_q;
      if (clr) begin
         esc_d = '0;
      end else if (match && (act == RACT_DEF) && (esc_q != EscMax)) begin
         esc_d = esc_q + 1'b1;
      end
      active_d = (state_d == ACTIVE);
      ract_d   = active_d;
      blk_d    = active_d & (act == RACT_DEF) & ~all_d;
      cust_d   = active_d & (act == RACT_CUST);
      wake_d   = active_d & bus.iDeepestSleep;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         esc_q   <= '0;
         all_q   <= 1'b0;
         wake_q  <= 1'b0;
         blk_q   <= 1'b0;
         cust_q  <= 1'b0;
         ract_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         esc_q   <= esc_d;
         all_q   <= all_d;
         wake_q  <= wake_d;
         blk_q   <= blk_d;
         cust_q  <= cust_d;
         ract_q  <= ract_d;
      end
   end

   assign bus.oWake         = wake_q;
   assign bus.oRstBlock     = blk_q;
   assign bus.oRstAll       = all_q;
   assign bus.oRstCustom    = cust_q;
   assign bus.oRstRstAction = ract_q;
   assign bus.oEscCnt       = esc_q;

endmodule

// File: tb/tb_i3c_reset_detector_sync.sv
// Self-checking bench for i3c_reset_detector_sync: table of reset patterns plus hand-written
// sequences; expected output vectors are queued with their due cycle and checked on arrival.
module tb_i3c_reset_detector_sync;

   logic clk = 1'b0;
   logic RST;
   logic slave_en;

   always #5 clk = ~clk;

   i3c_reset_detector_sync_if #(.ESC_W(3)) bus ();

   i3c_reset_detector_sync #(
      .SRST_EDGES (7),
      .FILT_CYC   (2),
      .ESC_LIMIT  (1),
      .ESC_W      (3)
   ) dut (
      .clk              (clk),
      .RST              (RST),
      .i3c_slave_active (slave_en),
      .bus              (bus)
   );

   // Output vector: {wake, block, all, custom, rstact, esc[2:0]}
   typedef struct {
      string      name;
      bit         do_rst;
      int         n_falls;
      bit         glitch;
      logic [3:0] ract;
      logic       sleep;
      logic [7:0] e_pre;
      logic [7:0] e_act;
      logic [7:0] e_after;
   } vec_t;

   typedef struct {
      int         due;
      logic [7:0] exp;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [7:0] outs();
      return {bus.oWake, bus.oRstBlock, bus.oRstAll, bus.oRstCustom, bus.oRstRstAction,
              bus.oEscCnt};
   endfunction

   task automatic add_vec(input string nm, input bit r, input int n, input bit g,
                          input logic [3:0] ra, input logic sl,
                          input logic [7:0] p, input logic [7:0] a, input logic [7:0] f);
      vec_t v;
      v.name = nm; v.do_rst = r; v.n_falls = n; v.glitch = g; v.ract = ra; v.sleep = sl;
      v.e_pre = p; v.e_act = a; v.e_after = f;
      vecs.push_back(v);
   endtask

   task automatic expect_at(input int due, input logic [7:0] e, input string nm);
      exp_t x;
      x.due = due; x.exp = e; x.name = nm;
      sb.push_back(x);
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t x;
         x = sb.pop_front();
         n_chk++;
         if (x.due != cyc)
            $display("FAIL %s: check slipped, due cycle %0d reached at %0d", x.name, x.due, cyc);
         else if (outs() !== x.exp)
            $display("FAIL %s: got %b expected %b (cycle %0d)", x.name, outs(), x.exp, cyc);
         else
            n_pass++;
      end
   endtask

   task automatic hold(input int n);
      repeat (n) step();
   endtask

   task automatic drive(input logic scl, input logic sda, input int n);
      bus.pin_SCL_in = scl;
      bus.pin_SDA_in = sda;
      hold(n);
   endtask

   task automatic do_reset(input string nm);
      RST = 1'b1;
      expect_at(cyc + 1, 8'h00, nm);
      step();
      RST = 1'b0;
      step();
   endtask

   // Raw pin change at cycle c reaches the outputs at c+5 (2 sync + 2 filter + 1).
   task automatic run_vec(input vec_t v);
      int c;
      bus.iRstAction    = v.ract;
      bus.iDeepestSleep = v.sleep;
      if (v.do_rst) do_reset({v.name, "_rst"});
      drive(1'b0, 1'b1, 4);
      for (int i = 0; i < v.n_falls; i++) begin
         drive(1'b0, 1'b0, 4);
         drive(1'b0, 1'b1, 4);
         if (v.glitch && i == 2) begin
            drive(1'b0, 1'b0, 1);
            drive(1'b0, 1'b1, 4);
         end
      end
      drive(1'b1, 1'b1, 4);
      drive(1'b1, 1'b0, 4);
      c = cyc;
      bus.pin_SDA_in = 1'b1;
      expect_at(c + 4, v.e_pre, {v.name, "_pre"});
      expect_at(c + 5, v.e_act, {v.name, "_act"});
      expect_at(c + 8, v.e_act, {v.name, "_hold"});
      hold(9);
      c = cyc;
      bus.pin_SCL_in = 1'b0;
      expect_at(c + 4, v.e_act, {v.name, "_scl_pre"});
      expect_at(c + 5, v.e_after, {v.name, "_after"});
      hold(6);
      drive(1'b1, 1'b1, 6);
   endtask

   task automatic clr_sequence();
      int c;
      c = cyc;
      bus.iRstAction = 4'b1000;
      expect_at(c + 1, 8'h20, "clr_zeroes_esc");
      expect_at(c + 4, 8'h20, "clr_keeps_all");
      hold(5);
      bus.iRstAction = 4'b0000;
      do_reset("rst_clears_all");
   endtask

   initial begin
      int c;
      RST               = 1'b1;
      slave_en          = 1'b1;
      bus.pin_SCL_in    = 1'b1;
      bus.pin_SDA_in    = 1'b1;
      bus.iDeepestSleep = 1'b0;
      bus.iRstAction    = 4'b0000;

      add_vec("def_first",    1, 7, 0, 4'b0000, 0, 8'h00, 8'h49, 8'h01);
      add_vec("def_escalate", 0, 7, 0, 4'b0000, 0, 8'h01, 8'h2A, 8'h22);
      add_vec("short6",       1, 6, 0, 4'b0000, 0, 8'h00, 8'h00, 8'h00);
      add_vec("full_after",   0, 7, 0, 4'b0001, 0, 8'h00, 8'h28, 8'h20);
      add_vec("glitch6",      1, 6, 1, 4'b0000, 0, 8'h00, 8'h00, 8'h00);
      add_vec("glitch7",      1, 7, 1, 4'b0000, 0, 8'h00, 8'h49, 8'h01);
      add_vec("custom",       1, 7, 0, 4'b0011, 0, 8'h00, 8'h18, 8'h00);
      add_vec("sleep_wake",   1, 7, 0, 4'b1001, 1, 8'h00, 8'h88, 8'h00);
      add_vec("full_fresh",   1, 7, 0, 4'b0001, 0, 8'h00, 8'h28, 8'h20);

      step();
      do_reset("reset");

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i]);
         if (vecs[i].name == "def_escalate") clr_sequence();
      end

      // oRstAll is 1 here; slave deactivation clears it on the next clock.
      c = cyc;
      slave_en = 1'b0;
      expect_at(c + 1, 8'h00, "inactive_clears_all");
      step();
      slave_en = 1'b1;
      step();

      // RST while in WAIT_P aborts the pattern; the following P must do nothing.
      bus.iRstAction    = 4'b0000;
      bus.iDeepestSleep = 1'b0;
      do_reset("waitp_pre_rst");
      drive(1'b0, 1'b1, 4);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b0, 4);
         drive(1'b0, 1'b1, 4);
      end
      drive(1'b1, 1'b1, 4);
      drive(1'b1, 1'b0, 6);
      do_reset("waitp_rst");
      hold(6);
      c = cyc;
      bus.pin_SDA_in = 1'b1;
      expect_at(c + 5, 8'h00, "waitp_p_ignored");
      expect_at(c + 8, 8'h00, "waitp_p_ignored_hold");
      hold(10);

      hold(3);
      while (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         n_chk++;
         $display("FAIL %s: never checked, due cycle %0d, ended at %0d", x.name, x.due, cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
